// File: rtl/idct_block_arbiter.sv
// Block-granular two-requester arbiter in front of a shared stream IDCT engine; an in-order
// tag FIFO routes returned blocks. Define IDCT_ARB_STRICT_PRIO_EN for strict requester-0 priority.
module idct_block_arbiter #(
    parameter int BEATS_PER_BLOCK = 8,
    parameter int MAX_OUTSTANDING = 4,
    parameter int DATA_W          = 128
) (
    input  logic                               i_aclk,
    input  logic                               i_aresetn,
    input  logic                               i_in0_t_valid,
    output logic                               o_in0_t_ready,
    input  logic [DATA_W-1:0]                  i_in0_t_data,
    input  logic                               i_in0_t_last,
    input  logic                               i_in1_t_valid,
    output logic                               o_in1_t_ready,
    input  logic [DATA_W-1:0]                  i_in1_t_data,
    input  logic                               i_in1_t_last,
    output logic                               o_eng_in_t_valid,
    input  logic                               i_eng_in_t_ready,
    output logic [DATA_W-1:0]                  o_eng_in_t_data,
    output logic                               o_eng_in_t_last,
    input  logic                               i_eng_out_t_valid,
    output logic                               o_eng_out_t_ready,
    input  logic [DATA_W-1:0]                  i_eng_out_t_data,
    output logic                               o_out0_t_valid,
    input  logic                               i_out0_t_ready,
    output logic [DATA_W-1:0]                  o_out0_t_data,
    output logic                               o_out0_t_last,
    output logic                               o_out1_t_valid,
    input  logic                               i_out1_t_ready,
    output logic [DATA_W-1:0]                  o_out1_t_data,
    output logic                               o_out1_t_last,
    output logic                               o_busy,
    output logic [$clog2(MAX_OUTSTANDING):0]   o_outstanding,
    output logic                               o_framing_err
);

    localparam int CNT_W = (BEATS_PER_BLOCK > 2) ? $clog2(BEATS_PER_BLOCK) : 1;
    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int OCC_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEATS_PER_BLOCK - 1);
    localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [OCC_W-1:0] OCC_ZERO = {OCC_W{1'b0}};
    localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(MAX_OUTSTANDING);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_GRANT0 = 2'd1;
    localparam logic [1:0] ST_GRANT1 = 2'd2;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_in_cnt;
    logic [CNT_W-1:0] r_out_cnt;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [OCC_W-1:0] r_count;
    logic             r_tag_mem [MAX_OUTSTANDING];
    logic             r_framing_err;
`ifndef IDCT_ARB_STRICT_PRIO_EN
    logic             r_last_served;
`endif

    logic w_fifo_full;
    logic w_fifo_empty;
    logic w_grant;
    logic w_winner;
    logic w_src_last;
    logic w_in_final;
    logic w_in_hs;
    logic w_head;
    logic w_out_final;
    logic w_out_hs;
    logic w_pop;

    // Arbitration: a grant is only issued from IDLE with room for another tag.
    always_comb begin
        w_fifo_full  = (r_count == OCC_FULL);
        w_fifo_empty = (r_count == OCC_ZERO);
        w_grant      = (r_state == ST_IDLE) && !w_fifo_full && (i_in0_t_valid || i_in1_t_valid);
`ifdef IDCT_ARB_STRICT_PRIO_EN
        w_winner     = ~i_in0_t_valid;
`else
        // Requester 1 wins when alone, or on a tie when requester 0 was served last.
        w_winner     = i_in1_t_valid & ~(i_in0_t_valid & r_last_served);
`endif
    end

    // Input mux: the granted requester drives the engine, t_last regenerated from the beat count.
    always_comb begin
        o_eng_in_t_valid = 1'b0;
        o_eng_in_t_data  = {DATA_W{1'b0}};
        o_in0_t_ready    = 1'b0;
        o_in1_t_ready    = 1'b0;
        w_src_last       = 1'b0;
        case (r_state)
            ST_GRANT0: begin
                o_eng_in_t_valid = i_in0_t_valid;
                o_eng_in_t_data  = i_in0_t_data;
                o_in0_t_ready    = i_eng_in_t_ready;
                w_src_last       = i_in0_t_last;
            end
            ST_GRANT1: begin
                o_eng_in_t_valid = i_in1_t_valid;
                o_eng_in_t_data  = i_in1_t_data;
                o_in1_t_ready    = i_eng_in_t_ready;
                w_src_last       = i_in1_t_last;
            end
            default: begin
                o_eng_in_t_valid = 1'b0;
            end
        endcase
        w_in_final      = (r_in_cnt == CNT_LAST);
        o_eng_in_t_last = (r_state != ST_IDLE) && w_in_final;
        w_in_hs         = o_eng_in_t_valid & i_eng_in_t_ready;
    end

    // Output routing: the FIFO head tag selects the destination; nothing moves while it is empty.
    always_comb begin
        w_head            = r_tag_mem[r_rd_ptr];
        w_out_final       = (r_out_cnt == CNT_LAST);
        o_out0_t_valid    = i_eng_out_t_valid & ~w_fifo_empty & ~w_head;
        o_out1_t_valid    = i_eng_out_t_valid & ~w_fifo_empty & w_head;
        o_out0_t_data     = i_eng_out_t_data;
        o_out1_t_data     = i_eng_out_t_data;
        o_out0_t_last     = w_out_final & ~w_head;
        o_out1_t_last     = w_out_final & w_head;
        o_eng_out_t_ready = ~w_fifo_empty & (w_head ? i_out1_t_ready : i_out0_t_ready);
        w_out_hs          = i_eng_out_t_valid & o_eng_out_t_ready;
        w_pop             = w_out_hs & w_out_final;
    end

    // Input FSM, input beat counter, round-robin memory and sticky framing flag.
    always_ff @(posedge i_aclk) begin
        if (!i_aresetn) begin
            r_state       <= ST_IDLE;
            r_in_cnt      <= CNT_ZERO;
            r_framing_err <= 1'b0;
`ifndef IDCT_ARB_STRICT_PRIO_EN
            r_last_served <= 1'b1;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant) begin
                        r_state <= w_winner ? ST_GRANT1 : ST_GRANT0;
                    end
                end
                ST_GRANT0, ST_GRANT1: begin
                    if (w_in_hs && w_in_final) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
            if (w_in_hs) begin
                r_in_cnt <= w_in_final ? CNT_ZERO : (r_in_cnt + CNT_ONE);
            end
`ifndef IDCT_ARB_STRICT_PRIO_EN
            if (w_in_hs && w_in_final) begin
                r_last_served <= (r_state == ST_GRANT1);
            end
`endif
            if (w_in_hs && (w_src_last != w_in_final)) begin
                r_framing_err <= 1'b1;
            end
        end
    end

    // Tag FIFO (push on grant, pop on final returned beat) and output beat counter.
    always_ff @(posedge i_aclk) begin
        if (!i_aresetn) begin
            r_wr_ptr  <= PTR_ZERO;
            r_rd_ptr  <= PTR_ZERO;
            r_count   <= OCC_ZERO;
            r_out_cnt <= CNT_ZERO;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                r_tag_mem[i] <= 1'b0;
            end
        end else begin
            if (w_grant) begin
                r_tag_mem[r_wr_ptr] <= w_winner;
                r_wr_ptr            <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr  <= r_rd_ptr + PTR_ONE;
                r_out_cnt <= CNT_ZERO;
            end else if (w_out_hs) begin
                r_out_cnt <= r_out_cnt + CNT_ONE;
            end
            case ({w_grant, w_pop})
                2'b10:   r_count <= r_count + OCC_ONE;
                2'b01:   r_count <= r_count - OCC_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_busy        = (r_state != ST_IDLE) | ~w_fifo_empty;
    assign o_outstanding = r_count;
    assign o_framing_err = r_framing_err;

endmodule

// File: tb/tb_idct_block_arbiter.sv
// Scoreboard bench for idct_block_arbiter: requester drivers, 3-cycle engine delay line,
// per-output expected queues filled when blocks are queued.
module tb_idct_block_arbiter;
    localparam int BPB  = 8;
    localparam int MAXO = 4;
    localparam int DW   = 128;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          aresetn;
    logic          i_in0_t_valid, o_in0_t_ready, i_in0_t_last;
    logic [DW-1:0] i_in0_t_data;
    logic          i_in1_t_valid, o_in1_t_ready, i_in1_t_last;
    logic [DW-1:0] i_in1_t_data;
    logic          o_eng_in_t_valid, i_eng_in_t_ready, o_eng_in_t_last;
    logic [DW-1:0] o_eng_in_t_data;
    logic          i_eng_out_t_valid, o_eng_out_t_ready;
    logic [DW-1:0] i_eng_out_t_data;
    logic          o_out0_t_valid, i_out0_t_ready, o_out0_t_last;
    logic [DW-1:0] o_out0_t_data;
    logic          o_out1_t_valid, i_out1_t_ready, o_out1_t_last;
    logic [DW-1:0] o_out1_t_data;
    logic          o_busy, o_framing_err;
    logic [2:0]    o_outstanding;

    idct_block_arbiter #(.BEATS_PER_BLOCK(BPB), .MAX_OUTSTANDING(MAXO), .DATA_W(DW)) dut (
        .i_aclk(clk), .i_aresetn(aresetn),
        .i_in0_t_valid(i_in0_t_valid), .o_in0_t_ready(o_in0_t_ready),
        .i_in0_t_data(i_in0_t_data), .i_in0_t_last(i_in0_t_last),
        .i_in1_t_valid(i_in1_t_valid), .o_in1_t_ready(o_in1_t_ready),
        .i_in1_t_data(i_in1_t_data), .i_in1_t_last(i_in1_t_last),
        .o_eng_in_t_valid(o_eng_in_t_valid), .i_eng_in_t_ready(i_eng_in_t_ready),
        .o_eng_in_t_data(o_eng_in_t_data), .o_eng_in_t_last(o_eng_in_t_last),
        .i_eng_out_t_valid(i_eng_out_t_valid), .o_eng_out_t_ready(o_eng_out_t_ready),
        .i_eng_out_t_data(i_eng_out_t_data),
        .o_out0_t_valid(o_out0_t_valid), .i_out0_t_ready(i_out0_t_ready),
        .o_out0_t_data(o_out0_t_data), .o_out0_t_last(o_out0_t_last),
        .o_out1_t_valid(o_out1_t_valid), .i_out1_t_ready(i_out1_t_ready),
        .o_out1_t_data(o_out1_t_data), .o_out1_t_last(o_out1_t_last),
        .o_busy(o_busy), .o_outstanding(o_outstanding), .o_framing_err(o_framing_err)
    );

    typedef struct {
        logic [DW-1:0] data;
        int            rdy;
    } eng_ent_t;

    int            n_cmp = 0;
    int            n_err = 0;
    int            cyc = 0;
    logic          flush = 1'b1;
    logic [DW:0]   src_q0[$];
    logic [DW:0]   src_q1[$];
    logic [DW:0]   exp_q0[$];
    logic [DW:0]   exp_q1[$];
    eng_ent_t      eng_q[$];
    int            grant_log[$];
    int            eng_beat = 0;
    int            eng_in_total = 0;
    int            first_hs_cyc = -1;
    int            last_hs_cyc = -1;
    int            max_outs = 0;

    always @(posedge clk) cyc = cyc + 1;

    // Requester 0 driver: presents the queue head, advances on a sampled handshake.
    always begin : drv0
        logic hs;
        @(negedge clk);
        hs = i_in0_t_valid && o_in0_t_ready;
        @(posedge clk);
        #1;
        if (flush) src_q0.delete();
        else if (hs && src_q0.size() > 0) void'(src_q0.pop_front());
        if (src_q0.size() > 0) begin
            i_in0_t_valid = 1'b1;
            {i_in0_t_last, i_in0_t_data} = src_q0[0];
        end else begin
            i_in0_t_valid = 1'b0;
            i_in0_t_last  = 1'b0;
            i_in0_t_data  = '0;
        end
    end

    // Requester 1 driver.
    always begin : drv1
        logic hs;
        @(negedge clk);
        hs = i_in1_t_valid && o_in1_t_ready;
        @(posedge clk);
        #1;
        if (flush) src_q1.delete();
        else if (hs && src_q1.size() > 0) void'(src_q1.pop_front());
        if (src_q1.size() > 0) begin
            i_in1_t_valid = 1'b1;
            {i_in1_t_last, i_in1_t_data} = src_q1[0];
        end else begin
            i_in1_t_valid = 1'b0;
            i_in1_t_last  = 1'b0;
            i_in1_t_data  = '0;
        end
    end

    // Engine model: identity transform with a 3-cycle delay; checks regenerated t_last.
    always begin : engine
        logic          in_hs, out_hs;
        logic [DW-1:0] in_data;
        @(negedge clk);
        in_hs   = o_eng_in_t_valid && i_eng_in_t_ready;
        out_hs  = i_eng_out_t_valid && o_eng_out_t_ready;
        in_data = o_eng_in_t_data;
        if (in_hs) begin
            n_cmp++;
            if (o_eng_in_t_last !== (eng_beat == BPB - 1)) begin
                n_err++;
                $display("FAIL eng_in_last beat=%0d got=%b want=%b", eng_beat, o_eng_in_t_last, (eng_beat == BPB - 1));
            end
        end
        @(posedge clk);
        #1;
        if (flush) begin
            eng_q.delete();
            eng_beat = 0;
        end else begin
            if (out_hs && eng_q.size() > 0) void'(eng_q.pop_front());
            if (in_hs) begin
                if (eng_beat == 0) grant_log.push_back(int'(in_data[23:16]));
                if (first_hs_cyc < 0) first_hs_cyc = cyc;
                last_hs_cyc = cyc;
                eng_q.push_back('{data: in_data, rdy: cyc + 3});
                eng_beat = (eng_beat == BPB - 1) ? 0 : eng_beat + 1;
                eng_in_total++;
            end
        end
        if (eng_q.size() > 0 && cyc >= eng_q[0].rdy) begin
            i_eng_out_t_valid = 1'b1;
            i_eng_out_t_data  = eng_q[0].data;
        end else begin
            i_eng_out_t_valid = 1'b0;
            i_eng_out_t_data  = '0;
        end
    end

    // Scoreboard: every output handshake must match the head of that requester's queue.
    always @(negedge clk) begin
        logic [DW:0] e;
        if (int'(o_outstanding) > max_outs) max_outs = int'(o_outstanding);
        if (o_out0_t_valid && i_out0_t_ready) begin
            n_cmp++;
            if (exp_q0.size() == 0) begin
                n_err++;
                $display("FAIL out0_unexpected got data=%h last=%b want none", o_out0_t_data, o_out0_t_last);
            end else begin
                e = exp_q0.pop_front();
                if ({o_out0_t_last, o_out0_t_data} !== e) begin
                    n_err++;
                    $display("FAIL out0_beat got %h/%b want %h/%b", o_out0_t_data, o_out0_t_last, e[DW-1:0], e[DW]);
                end
            end
        end
        if (o_out1_t_valid && i_out1_t_ready) begin
            n_cmp++;
            if (exp_q1.size() == 0) begin
                n_err++;
                $display("FAIL out1_unexpected got data=%h last=%b want none", o_out1_t_data, o_out1_t_last);
            end else begin
                e = exp_q1.pop_front();
                if ({o_out1_t_last, o_out1_t_data} !== e) begin
                    n_err++;
                    $display("FAIL out1_beat got %h/%b want %h/%b", o_out1_t_data, o_out1_t_last, e[DW-1:0], e[DW]);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // Queue one block (call at a negedge); bad_idx >= 0 moves the input t_last to that beat.
    task automatic push_block(input int rid, input int blk, input int bad_idx);
        logic [DW-1:0] d;
        logic          il;
        logic          el;
        for (int b = 0; b < BPB; b++) begin
            d  = DW'(rid * 65536 + blk * 256 + b);
            il = (bad_idx < 0) ? (b == BPB - 1) : (b == bad_idx);
            el = (b == BPB - 1);
            if (rid == 0) begin
                src_q0.push_back({il, d});
                exp_q0.push_back({el, d});
            end else begin
                src_q1.push_back({il, d});
                exp_q1.push_back({el, d});
            end
        end
    endtask

    task automatic wait_drain(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (src_q0.size() == 0 && src_q1.size() == 0 && exp_q0.size() == 0 &&
                exp_q1.size() == 0 && eng_q.size() == 0 && o_busy == 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        #1;
        aresetn = 1'b0;
        flush   = 1'b1;
        src_q0.delete(); src_q1.delete(); exp_q0.delete(); exp_q1.delete();
        repeat (n) @(posedge clk);
        #2;
        aresetn = 1'b1;
        flush   = 1'b0;
    endtask

    task automatic set_ready(input logic r0, input logic r1);
        @(posedge clk);
        #1;
        i_out0_t_ready = r0;
        i_out1_t_ready = r1;
    endtask

    task automatic test_reset();
        do_reset(2);
        @(negedge clk);
        n_cmp++;
        if ({o_in0_t_ready, o_in1_t_ready, o_eng_in_t_valid, o_eng_out_t_ready, o_out0_t_valid,
             o_out1_t_valid, o_busy, o_framing_err} !== 8'h00) begin
            n_err++;
            $display("FAIL reset_flags got %b want 00000000", {o_in0_t_ready, o_in1_t_ready, o_eng_in_t_valid,
                     o_eng_out_t_ready, o_out0_t_valid, o_out1_t_valid, o_busy, o_framing_err});
        end
        n_cmp++;
        if (o_outstanding !== 3'd0) begin
            n_err++;
            $display("FAIL reset_outstanding got %0d want 0", o_outstanding);
        end
    endtask

    task automatic test_single_block();
        bit ok;
        @(negedge clk);
        max_outs = 0;
        push_block(0, 0, -1);
        @(negedge clk);
        n_cmp++;
        if ({o_in0_t_ready, o_busy, o_outstanding} !== {1'b0, 1'b0, 3'd0}) begin
            n_err++;
            $display("FAIL single_bubble got ready=%b busy=%b outs=%0d want 0/0/0", o_in0_t_ready, o_busy, o_outstanding);
        end
        @(negedge clk);
        n_cmp++;
        if ({o_in0_t_ready, o_busy, o_outstanding} !== {1'b1, 1'b1, 3'd1}) begin
            n_err++;
            $display("FAIL single_granted got ready=%b busy=%b outs=%0d want 1/1/1", o_in0_t_ready, o_busy, o_outstanding);
        end
        wait_drain(200, ok);
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL single_drain got timeout want drained"); end
        n_cmp++;
        if (max_outs != 1 || o_outstanding !== 3'd0) begin
            n_err++;
            $display("FAIL single_outstanding got max=%0d now=%0d want 1/0", max_outs, o_outstanding);
        end
    endtask

`ifdef IDCT_ARB_STRICT_PRIO_EN
    task automatic test_strict_prio();
        bit ok;
        int want[6] = '{0, 0, 0, 0, 1, 1};
        do_reset(1);
        @(negedge clk);
        grant_log.delete();
        for (int b = 0; b < 4; b++) push_block(0, b, -1);
        for (int b = 0; b < 2; b++) push_block(1, b, -1);
        wait_drain(600, ok);
        n_cmp++;
        if (!ok || grant_log.size() != 6) begin
            n_err++;
            $display("FAIL strict_drain got ok=%0d grants=%0d want 1/6", ok, grant_log.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                n_cmp++;
                if (grant_log[i] != want[i]) begin
                    n_err++;
                    $display("FAIL strict_order idx=%0d got %0d want %0d", i, grant_log[i], want[i]);
                end
            end
        end
    endtask
`else
    task automatic test_tie();
        bit ok;
        do_reset(1);
        @(negedge clk);
        grant_log.delete();
        first_hs_cyc = -1;
        for (int b = 0; b < 4; b++) begin
            push_block(0, b, -1);
            push_block(1, b, -1);
        end
        wait_drain(600, ok);
        n_cmp++;
        if (!ok || grant_log.size() != 8) begin
            n_err++;
            $display("FAIL tie_drain got ok=%0d grants=%0d want 1/8", ok, grant_log.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                n_cmp++;
                if (grant_log[i] != (i % 2)) begin
                    n_err++;
                    $display("FAIL tie_order idx=%0d got %0d want %0d", i, grant_log[i], i % 2);
                end
            end
        end
        n_cmp++;
        if (last_hs_cyc - first_hs_cyc != 8 * (BPB + 1) - 2) begin
            n_err++;
            $display("FAIL tie_throughput got span=%0d want %0d", last_hs_cyc - first_hs_cyc, 8 * (BPB + 1) - 2);
        end
    endtask
`endif

    task automatic test_back_pressure();
        bit ok;
        int base;
        set_ready(1'b0, 1'b1);
        @(negedge clk);
        base = eng_in_total;
        for (int b = 0; b < 6; b++) push_block(0, 16 + b, -1);
        repeat (80) @(negedge clk);
        n_cmp++;
        if (o_outstanding !== 3'd4 || eng_in_total - base != 4 * BPB) begin
            n_err++;
            $display("FAIL bp_full got outs=%0d beats=%0d want 4/%0d", o_outstanding, eng_in_total - base, 4 * BPB);
        end
        n_cmp++;
        if ({i_in0_t_valid, o_in0_t_ready, o_out0_t_valid} !== 3'b101) begin
            n_err++;
            $display("FAIL bp_stalled got v/r/ov=%b want 101", {i_in0_t_valid, o_in0_t_ready, o_out0_t_valid});
        end
        set_ready(1'b1, 1'b1);
        wait_drain(600, ok);
        n_cmp++;
        if (!ok || o_outstanding !== 3'd0 || eng_in_total - base != 6 * BPB) begin
            n_err++;
            $display("FAIL bp_resume got ok=%0d outs=%0d beats=%0d want 1/0/%0d", ok, o_outstanding,
                     eng_in_total - base, 6 * BPB);
        end
    endtask

    task automatic test_framing();
        bit ok;
        @(negedge clk);
        n_cmp++;
        if (o_framing_err !== 1'b0) begin n_err++; $display("FAIL framing_clean got 1 want 0"); end
        push_block(1, 32, 4);
        wait_drain(200, ok);
        n_cmp++;
        if (!ok || o_framing_err !== 1'b1) begin
            n_err++;
            $display("FAIL framing_set got ok=%0d err=%b want 1/1", ok, o_framing_err);
        end
        push_block(1, 33, -1);
        wait_drain(200, ok);
        n_cmp++;
        if (!ok || o_framing_err !== 1'b1) begin
            n_err++;
            $display("FAIL framing_sticky got ok=%0d err=%b want 1/1", ok, o_framing_err);
        end
    endtask

    task automatic test_reset_mid_block();
        bit ok;
        bit hit;
        int base;
        @(negedge clk);
        push_block(0, 40, -1);
        wait_drain(200, ok);
        base = eng_in_total;
        push_block(1, 41, -1);
        hit = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (eng_in_total == base + 3) begin hit = 1'b1; break; end
        end
        n_cmp++;
        if (!hit) begin n_err++; $display("FAIL midrst_start got %0d beats want 3", eng_in_total - base); end
        #1;
        aresetn = 1'b0;
        flush   = 1'b1;
        src_q0.delete(); src_q1.delete(); exp_q0.delete(); exp_q1.delete();
        @(posedge clk);
        #2;
        aresetn = 1'b1;
        flush   = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({o_in0_t_ready, o_in1_t_ready, o_eng_in_t_valid, o_eng_out_t_ready, o_out0_t_valid,
             o_out1_t_valid, o_busy, o_framing_err, o_outstanding} !== 11'h000) begin
            n_err++;
            $display("FAIL midrst_state got %b want all zero", {o_in0_t_ready, o_in1_t_ready, o_eng_in_t_valid,
                     o_eng_out_t_ready, o_out0_t_valid, o_out1_t_valid, o_busy, o_framing_err, o_outstanding});
        end
        grant_log.delete();
        push_block(1, 42, -1);
        push_block(0, 42, -1);
        wait_drain(300, ok);
        n_cmp++;
        if (!ok || grant_log.size() != 2) begin
            n_err++;
            $display("FAIL midrst_drain got ok=%0d grants=%0d want 1/2", ok, grant_log.size());
        end else if (grant_log[0] != 0 || grant_log[1] != 1) begin
            n_err++;
            $display("FAIL midrst_order got %0d,%0d want 0,1", grant_log[0], grant_log[1]);
        end
    endtask

    initial begin
        aresetn          = 1'b0;
        i_in0_t_valid    = 1'b0; i_in0_t_last = 1'b0; i_in0_t_data = '0;
        i_in1_t_valid    = 1'b0; i_in1_t_last = 1'b0; i_in1_t_data = '0;
        i_eng_in_t_ready = 1'b1;
        i_eng_out_t_valid = 1'b0; i_eng_out_t_data = '0;
        i_out0_t_ready   = 1'b1;
        i_out1_t_ready   = 1'b1;
        test_reset();
        test_single_block();
`ifdef IDCT_ARB_STRICT_PRIO_EN
        test_strict_prio();
`else
        test_tie();
`endif
        test_back_pressure();
        test_framing();
        test_reset_mid_block();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
